counter_event_tx: RTL and testbench

- Source-side transmitter for the counter data-crossing path; one instance per counter channel, clocked in that channel's source clock.
- Accumulates event pulses into a pending count.
- Ships each count to the destination domain over a 4-phase req/ack handshake, holding the data bus stable while req is high.
- The destination side synchronizes o_req and captures o_data; its ack returns asynchronously and is synchronized here.

---
 rtl/counter_event_tx.sv | 107 ++++++++++
 tb/tb_counter_event_tx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_event_tx.sv
// Source-side transmitter for one counter channel: accumulates event strobes
// and ships each pending count across a 4-phase req/ack handshake.
module counter_event_tx #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk_din,
  input  logic             i_rstn_din,
  input  logic             i_event,
  input  logic             i_ack,
  input  logic             i_ovf_clr,
  output logic             o_req,
  output logic [CNT_W-1:0] o_data,
  output logic [CNT_W-1:0] o_pending,
  output logic             o_busy,
  output logic             o_overflow
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   launch;
  logic [CNT_W-1:0]       acc;
  logic [CNT_W-1:0]       acc_base;
  logic [CNT_W-1:0]       acc_next;
  logic                   ovf_set;

  // i_ack is asynchronous; only the last synchronizer stage is ever used
  always_ff @(posedge i_clk_din or negedge i_rstn_din) begin
    if (!i_rstn_din) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], i_ack};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk_din or negedge i_rstn_din) begin
    if (!i_rstn_din) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (acc != '0) begin
          launch     = 1'b1;
          state_next = REQ;
        end
      end
      REQ:      if (ack_s)  state_next = WAIT_LOW;
      WAIT_LOW: if (!ack_s) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // A launch empties the accumulator, so an event in the launch cycle lands in a fresh count
  always_comb begin
    acc_base = launch ? '0 : acc;
    acc_next = acc_base;
    ovf_set  = 1'b0;
    if (i_event) begin
      if (acc_base == CNT_MAX) begin
        ovf_set = 1'b1;
      end else begin
        acc_next = acc_base + CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk_din or negedge i_rstn_din) begin
    if (!i_rstn_din) begin
      o_req      <= 1'b0;
      o_busy     <= 1'b0;
      o_data     <= '0;
      acc        <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_req      <= (state_next == REQ);
      o_busy     <= (state_next != IDLE);
      if (launch) begin
        o_data <= acc;
      end
      acc        <= acc_next;
      o_overflow <= ovf_set | (o_overflow & ~i_ovf_clr);
    end
  end

  assign o_pending = acc;

endmodule

// File: tb/tb_counter_event_tx.sv
// Scoreboard bench for counter_event_tx: directed transfers push expected
// o_data values; an independent monitor pops them on every req rise.
module tb_counter_event_tx;

  localparam int CNT_W       = 4;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ev;
  logic             ack;
  logic             ovf_clr;
  logic             req;
  logic             busy;
  logic             ovf;
  logic [CNT_W-1:0] data;
  logic [CNT_W-1:0] pending;

  int checks   = 0;
  int errors   = 0;
  int exp_q[$];
  int xfer_sum = 0;
  bit directed = 1'b1;
  bit ack_hold = 1'b0;
  bit ack_man  = 1'b0;
  bit ack_man_val = 1'b0;
  int ack_dly  = 3;

  always #5 clk = ~clk;

  counter_event_tx #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .i_clk_din  (clk),
    .i_rstn_din (rst_n),
    .i_event    (ev),
    .i_ack      (ack),
    .i_ovf_clr  (ovf_clr),
    .o_req      (req),
    .o_data     (data),
    .o_pending  (pending),
    .o_busy     (busy),
    .o_overflow (ovf)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while ((exp_q.size() != 0 || busy || req || pending != '0) && n < lim) begin
      cyc();
      n++;
    end
    check("done_in_time", int'(n < lim), 1);
  endtask

  // Destination-side ack responder, driven on the falling edge
  initial begin : responder
    int rs   = 0;
    int rcnt = 0;
    ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack = 1'b0;
        rs  = 0;
      end else if (ack_man) begin
        ack = ack_man_val;
      end else begin
        case (rs)
          0: if (req && !ack_hold) begin rcnt = ack_dly; rs = 1; end
          1: if (rcnt == 0) begin ack = 1'b1; rs = 2; end else rcnt--;
          2: if (!req) begin rcnt = ack_dly; rs = 3; end
          3: if (rcnt == 0) begin ack = 1'b0; rs = 0; end else rcnt--;
          default: rs = 0;
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks protocol timing
  initial begin : monitor
    bit req_prev = 1'b0;
    bit ack_prev = 1'b0;
    bit cnting   = 1'b0;
    int acnt     = 0;
    int held     = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        req_prev = 1'b0;
        ack_prev = 1'b0;
        cnting   = 1'b0;
        continue;
      end
      if (ack && !ack_prev) begin
        check("ack_has_req", int'(req), 1);
        cnting = 1'b1;
        acnt   = 1;
      end else if (cnting) begin
        acnt++;
      end
      if (req && !req_prev) begin
        held     = int'(data);
        xfer_sum += held;
        if (exp_q.size() > 0) begin
          check("xfer_data", held, exp_q.pop_front());
        end else if (directed) begin
          check("unexpected_req", 1, 0);
        end
      end
      if (req && req_prev) check("data_stable", int'(data), held);
      if (!req && req_prev && cnting) begin
        check("ack_to_req_fall", acnt, SYNC_STAGES + 1);
        cnting = 1'b0;
      end
      req_prev = req;
      ack_prev = ack;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s0;
    int ev_cnt;
    rst_n   = 1'b0;
    ev      = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", int'(req), 0);
    check("rst_data", int'(data), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    cyc();
    cyc();
    check("idle_no_req", int'(req), 0);

    // single event: capture at E0, launch at E1
    exp_q.push_back(1);
    ev = 1'b1;
    cyc();
    ev = 1'b0;
    check("single_pend_e0", int'(pending), 1);
    check("single_req_e0", int'(req), 0);
    cyc();
    check("single_req_e1", int'(req), 1);
    check("single_data_e1", int'(data), 1);
    check("single_pend_e1", int'(pending), 0);
    wait_done(100);
    check("single_busy_end", int'(busy), 0);

    // burst of five with ack held off
    ack_hold = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(4);
    s0 = xfer_sum;
    ev = 1'b1;
    repeat (5) cyc();
    ev = 1'b0;
    check("burst_pending", int'(pending), 4);
    check("burst_req", int'(req), 1);
    check("burst_data", int'(data), 1);
    check("burst_busy", int'(busy), 1);
    ack_hold = 1'b0;
    wait_done(200);
    check("burst_total", xfer_sum - s0, 5);

    // event coincident with the launch edge, ack driven by hand
    ack_man_val = 1'b0;
    ack_man     = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(3);
    exp_q.push_back(1);
    ev = 1'b1;
    cyc();
    ev = 1'b0;
    cyc();
    check("coin_first_data", int'(data), 1);
    ev = 1'b1;
    repeat (3) cyc();
    ev = 1'b0;
    check("coin_pending3", int'(pending), 3);
    ack_man_val = 1'b1;
    repeat (3) cyc();
    check("coin_req_low", int'(req), 0);
    check("coin_busy_wait", int'(busy), 1);
    ack_man_val = 1'b0;
    repeat (3) cyc();
    check("coin_idle", int'(busy), 0);
    check("coin_no_relaunch", int'(req), 0);
    ev = 1'b1;
    cyc();
    ev = 1'b0;
    check("coin_req", int'(req), 1);
    check("coin_data", int'(data), 3);
    check("coin_pending1", int'(pending), 1);
    ack_man = 1'b0;
    wait_done(200);

    // saturation and overflow clear
    ack_hold = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(15);
    ev = 1'b1;
    repeat (20) cyc();
    ev = 1'b0;
    check("sat_pending", int'(pending), 15);
    check("sat_ovf", int'(ovf), 1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    check("sat_clr", int'(ovf), 0);
    check("sat_pending_kept", int'(pending), 15);
    ev      = 1'b1;
    ovf_clr = 1'b1;
    cyc();
    ev      = 1'b0;
    ovf_clr = 1'b0;
    check("sat_set_wins", int'(ovf), 1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    check("sat_clr2", int'(ovf), 0);
    ack_hold = 1'b0;
    wait_done(200);

    // reset in the middle of a transfer carrying 7
    ack_man_val = 1'b0;
    ack_man     = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(7);
    ev = 1'b1;
    cyc();
    ev = 1'b0;
    cyc();
    ev = 1'b1;
    repeat (7) cyc();
    ev = 1'b0;
    check("mid_pending7", int'(pending), 7);
    ack_man_val = 1'b1;
    repeat (3) cyc();
    ack_man_val = 1'b0;
    repeat (4) cyc();
    check("mid_req", int'(req), 1);
    check("mid_data", int'(data), 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", int'(req), 0);
    check("mid_rst_data", int'(data), 0);
    check("mid_rst_pending", int'(pending), 0);
    check("mid_rst_busy", int'(busy), 0);
    repeat (2) cyc();
    rst_n   = 1'b1;
    ack_man = 1'b0;
    repeat (10) begin
      cyc();
      check("post_rst_no_req", int'(req), 0);
    end
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_queue", exp_q.size(), 0);

    // random stress: conservation of events
    directed = 1'b0;
    s0       = xfer_sum;
    ev_cnt   = 0;
    for (int i = 0; i < 10000; i++) begin
      ev      = ($urandom_range(0, 7) == 0);
      ack_dly = int'($urandom_range(0, 10));
      cyc();
      if (ev) ev_cnt++;
    end
    ev = 1'b0;
    wait_done(500);
    check("rand_total", xfer_sum - s0, ev_cnt);
    check("rand_ovf", int'(ovf), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
